// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives a req/ack data-memory port, stalls upstream while an
// access is outstanding, and presents selected write-back data qualified by validOut.
//
// state | meaning
// IDLE  | no access outstanding; launches aligned accesses, passes non-access ops through
// BUSY  | request held, waiting for memAck or wait-counter terminal count
// DONE  | access finished; instruction leaves M stage this cycle

module mem_stage_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic [15:0] aluFinalM,
  input  logic [15:0] addPCM,
  input  logic [15:0] wrtDataM,
  input  logic [15:0] imm8M,
  input  logic        memWrtM,
  input  logic        readEnM,
  input  logic [1:0]  wbDataSelM,
  input  logic        regWrtM,
  output logic        memReq,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWrData,
  input  logic [15:0] memRdData,
  input  logic        memAck,
  output logic        stallM,
  output logic [15:0] wbDataOut,
  output logic        regWrtOut,
  output logic        validOut,
  output logic        errOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam bit             TMO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_tmo, w_tmo_nxt;
  logic [15:0]      r_rd_data, w_rd_data_nxt;

  logic        w_access;
  logic        w_is_load;
  logic        w_misalign;
  logic        w_go;
  logic        w_tmo_hit;
  logic        w_req;
  logic        w_stall;
  logic        w_valid;
  logic        w_err;
  logic [15:0] w_wb_sel;

  // Both enables set is treated as a store, so only a pure read updates r_rd_data.
  assign w_access   = validM & (readEnM | memWrtM);
  assign w_is_load  = readEnM & ~memWrtM;
  assign w_misalign = w_access & aluFinalM[0];
  assign w_go       = w_access & ~aluFinalM[0];
  // The launch cycle in IDLE counts as the first wait cycle, so BUSY starts at 1.
  assign w_tmo_hit  = TMO_EN && (r_cnt >= TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_rd_data <= w_rd_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
    w_rd_data_nxt = r_rd_data;
    w_req         = 1'b0;
    w_stall       = 1'b0;
    w_valid       = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_tmo_nxt = 1'b0;
        if (w_go) begin
          w_req   = 1'b1;
          w_stall = 1'b1;
          if (memAck) begin
            if (w_is_load) w_rd_data_nxt = memRdData;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_BUSY;
          end
        end else begin
          w_valid = validM;
          w_err   = w_misalign;
        end
      end
      S_BUSY: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (memAck) begin
          if (w_is_load) w_rd_data_nxt = memRdData;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else if (w_tmo_hit) begin
          if (w_is_load) w_rd_data_nxt = 16'hFFFF;
          w_tmo_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_valid     = 1'b1;
        w_err       = r_tmo;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_wb_sel = r_rd_data;
    case (wbDataSelM)
      2'b00:   w_wb_sel = r_rd_data;
      2'b01:   w_wb_sel = aluFinalM;
      2'b10:   w_wb_sel = addPCM;
      2'b11:   w_wb_sel = imm8M;
      default: w_wb_sel = r_rd_data;
    endcase
  end

  // Gating with rst makes the handshake and stall drop the instant reset asserts.
  assign memReq    = rst & w_req;
  assign stallM    = rst & w_stall;
  assign validOut  = rst & w_valid;
  assign errOut    = validOut & w_err;
  assign regWrtOut = regWrtM & validOut & ~errOut;
  assign wbDataOut = validOut ? w_wb_sel : 16'h0000;

  assign memWr     = memWrtM;
  assign memAddr   = aluFinalM;
  assign memWrData = wrtDataM;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: issue() queues the expected retirement record,
// the negedge monitor counts req/stall cycles and compares when validOut appears.

module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, memWrtM, readEnM, regWrtM, memAck;
  logic [15:0] aluFinalM, addPCM, wrtDataM, imm8M, memRdData;
  logic [1:0]  wbDataSelM;
  logic        memReq, memWr, stallM, regWrtOut, validOut, errOut;
  logic [15:0] memAddr, memWrData, wbDataOut;

  int n_checks = 0;
  int n_errors = 0;
  int seq      = 0;
  int mon_req  = 0;
  int mon_stall = 0;

  typedef struct {
    int          id;
    logic [15:0] wb;
    logic        rw;
    logic        err;
    int          nreq;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t q[$];

  mem_stage_ctrl #(.TIMEOUT_CYC(4), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .validM(validM), .aluFinalM(aluFinalM), .addPCM(addPCM),
    .wrtDataM(wrtDataM), .imm8M(imm8M), .memWrtM(memWrtM), .readEnM(readEnM),
    .wbDataSelM(wbDataSelM), .regWrtM(regWrtM), .memReq(memReq), .memWr(memWr),
    .memAddr(memAddr), .memWrData(memWrData), .memRdData(memRdData), .memAck(memAck),
    .stallM(stallM), .wbDataOut(wbDataOut), .regWrtOut(regWrtOut), .validOut(validOut),
    .errOut(errOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_req   = 0;
      mon_stall = 0;
      q.delete();
    end else begin
      if (memReq) begin
        mon_req++;
        if (q.size() == 0) begin
          chk("unexpected_memReq", 32'(memReq), 32'd0);
        end else begin
          chk($sformatf("memWr%0d", q[0].id), 32'(memWr), 32'(q[0].wr));
          chk($sformatf("memAddr%0d", q[0].id), 32'(memAddr), 32'(q[0].addr));
          if (q[0].wr) chk($sformatf("memWrData%0d", q[0].id), 32'(memWrData), 32'(q[0].wdata));
        end
      end
      if (stallM) mon_stall++;
      if (validOut) begin
        if (q.size() == 0) begin
          chk("unexpected_validOut", 32'(validOut), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("wb%0d", e.id), 32'(wbDataOut), 32'(e.wb));
          chk($sformatf("regWrt%0d", e.id), 32'(regWrtOut), 32'(e.rw));
          chk($sformatf("err%0d", e.id), 32'(errOut), 32'(e.err));
          chk($sformatf("nreq%0d", e.id), 32'(mon_req), 32'(e.nreq));
          chk($sformatf("nstall%0d", e.id), 32'(mon_stall), 32'(e.nreq));
        end
        mon_req   = 0;
        mon_stall = 0;
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] sel, input logic rw,
                       input int ack_dly, input logic [15:0] rdat, input logic [15:0] e_wb,
                       input logic e_rw, input logic e_err, input int e_req);
    exp_t e;
    logic done;
    e.id = seq; e.wb = e_wb; e.rw = e_rw; e.err = e_err; e.nreq = e_req;
    e.wr = st; e.addr = addr; e.wdata = wdata;
    seq++;
    q.push_back(e);
    validM = 1'b1; readEnM = ld; memWrtM = st; aluFinalM = addr; wrtDataM = wdata;
    wbDataSelM = sel; regWrtM = rw; memRdData = rdat;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      memAck = (k == ack_dly);
      @(negedge clk);
      done = validOut;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL retire_timeout%0d actual=no_validOut expected=validOut", e.id);
    end
    validM = 1'b0; readEnM = 1'b0; memWrtM = 1'b0; memAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    validM = 1'b1; readEnM = 1'b1; memWrtM = 1'b0; aluFinalM = 16'h0010;
    wrtDataM = 16'h0000; wbDataSelM = 2'b01; regWrtM = 1'b1; memAck = 1'b1;
    memRdData = 16'hABCD; addPCM = 16'h0102; imm8M = 16'h00FF;
    #12;
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_stallM", 32'(stallM), 32'd0);
    chk("rst_validOut", 32'(validOut), 32'd0);
    chk("rst_errOut", 32'(errOut), 32'd0);
    chk("rst_regWrtOut", 32'(regWrtOut), 32'd0);
    chk("rst_wbDataOut", 32'(wbDataOut), 32'd0);
    validM = 1'b0; readEnM = 1'b0; memAck = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    //    ld    st    addr      wdata     sel    rw    ack rdat      exp_wb    rw    err   nreq
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 0,  16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1);
    issue(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b00, 1'b0, 3,  16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 4);
    issue(1'b0, 1'b0, 16'h00AA, 16'h0000, 2'b01, 1'b1, -1, 16'h0000, 16'h00AA, 1'b1, 1'b0, 0);
    issue(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b01, 1'b1, 0,  16'h2222, 16'h0011, 1'b0, 1'b1, 0);
    issue(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b1, 4,  16'h1111, 16'hFFFF, 1'b0, 1'b1, 4);
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b1, 1,  16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 2);
    issue(1'b1, 1'b1, 16'h0042, 16'h7777, 2'b00, 1'b0, 0,  16'hDEAD, 16'h5A5A, 1'b0, 1'b0, 1);
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b10, 1'b1, -1, 16'h0000, 16'h0102, 1'b1, 1'b0, 0);
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, -1, 16'h0000, 16'h00FF, 1'b0, 1'b0, 0);

    // Bubble carrying a stale load: must neither request nor retire.
    validM = 1'b0; readEnM = 1'b1; aluFinalM = 16'h0060; memAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    readEnM = 1'b0;

    issue(1'b0, 1'b1, 16'h0021, 16'h4444, 2'b01, 1'b1, 0,  16'h0000, 16'h0021, 1'b0, 1'b1, 0);

    // Reset in the middle of a BUSY load.
    begin
      exp_t e;
      e.id = seq; e.wb = 16'h0000; e.rw = 1'b0; e.err = 1'b0; e.nreq = 0;
      e.wr = 1'b0; e.addr = 16'h0050; e.wdata = 16'h0000;
      seq++;
      q.push_back(e);
    end
    validM = 1'b1; readEnM = 1'b1; memWrtM = 1'b0; aluFinalM = 16'h0050;
    wbDataSelM = 2'b00; regWrtM = 1'b1; memAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_memReq", 32'(memReq), 32'd1);
    chk("busy_stallM", 32'(stallM), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_memReq", 32'(memReq), 32'd0);
    chk("midrst_stallM", 32'(stallM), 32'd0);
    chk("midrst_validOut", 32'(validOut), 32'd0);
    validM = 1'b0; readEnM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, -1, 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 2,  16'h0F0F, 16'h0F0F, 1'b1, 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
